// File: rtl/clasificador_pulsacion_pkg.sv
// rtl/clasificador_pulsacion_pkg.sv - shared types and constants for the press classifier
package clasificador_pulsacion_pkg;

  // Width of every timer in the classifier
  localparam int unsigned ANCHO_CONT = 32;

  // Default clock rate: 50 MHz, expressed as cycles per millisecond
  localparam int unsigned CICLOS_MS_DEF = 50000;

  typedef enum logic [1:0] {
    REPOSO       = 2'd0,
    PRESIONADO   = 2'd1,
    ESPERA_DOBLE = 2'd2,
    LARGO        = 2'd3
  } estado_t;

endpackage

// File: rtl/temporizador_ms.sv
// rtl/temporizador_ms.sv - saturating cycle timer with clear, enable and terminal-count flag
module temporizador_ms
  import clasificador_pulsacion_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [ANCHO_CONT-1:0] limite,
  output logic                  fin
);

  logic [ANCHO_CONT-1:0] cuenta;

  // Terminal count is a plain compare so the owner sees it the cycle the limit is reached
  assign fin = (cuenta == limite);

  // Count enabled cycles; hold at the limit so an unattended timer can never wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta <= '0;
    end else if (clr) begin
      cuenta <= '0;
    end else if (en && !fin) begin
      cuenta <= cuenta + ANCHO_CONT'(1);
    end
  end

endmodule

// File: rtl/clasificador_pulsacion.sv
// rtl/clasificador_pulsacion.sv - turns a filtered button pulse train into short/long/double press events
module clasificador_pulsacion
  import clasificador_pulsacion_pkg::*;
#(
  parameter int unsigned CICLOS_MS = CICLOS_MS_DEF,
  parameter int unsigned HUECO_MS  = 4,
  parameter int unsigned LARGO_MS  = 500,
  parameter int unsigned DOBLE_MS  = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulso_ideal,
  output logic corta,
  output logic larga,
  output logic doble,
  output logic presionado
);

  localparam logic [ANCHO_CONT-1:0] G = ANCHO_CONT'(HUECO_MS * CICLOS_MS);
  localparam logic [ANCHO_CONT-1:0] L = ANCHO_CONT'(LARGO_MS * CICLOS_MS);
  localparam logic [ANCHO_CONT-1:0] V = ANCHO_CONT'(DOBLE_MS * CICLOS_MS);
  // The window is entered one cycle after the G-th low sample; trimming two cycles
  // places the short-press event exactly G+V cycles after the last high sample.
  localparam logic [ANCHO_CONT-1:0] V_FIN = V - ANCHO_CONT'(2);

  estado_t estado_q, estado_d;
  logic    segunda_q, segunda_d;
  logic    corta_d, larga_d, doble_d;

  logic hueco_clr, hueco_en, hueco_fin;
  logic tiempo_clr, tiempo_en, tiempo_fin;
  logic ventana_clr, ventana_en, ventana_fin;

  // Low run only matters while a press is alive; any high sample restarts it
  assign hueco_en   = !pulso_ideal && (estado_q == PRESIONADO || estado_q == LARGO);
  assign tiempo_en  = (estado_q == PRESIONADO);
  assign ventana_en = (estado_q == ESPERA_DOBLE);

  assign presionado = (estado_q == PRESIONADO) || (estado_q == LARGO);

  temporizador_ms u_hueco (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (hueco_clr),
    .en     (hueco_en),
    .limite (G),
    .fin    (hueco_fin)
  );

  temporizador_ms u_tiempo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tiempo_clr),
    .en     (tiempo_en),
    .limite (L),
    .fin    (tiempo_fin)
  );

  temporizador_ms u_ventana (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (ventana_clr),
    .en     (ventana_en),
    .limite (V_FIN),
    .fin    (ventana_fin)
  );

  // State, pair flag and one-cycle event registers; reset drops any pending event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= REPOSO;
      segunda_q <= 1'b0;
      corta     <= 1'b0;
      larga     <= 1'b0;
      doble     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      segunda_q <= segunda_d;
      corta     <= corta_d;
      larga     <= larga_d;
      doble     <= doble_d;
    end
  end

  // Next state, timer clears and event decisions; at most one event per transition
  always_comb begin
    estado_d    = estado_q;
    segunda_d   = segunda_q;
    corta_d     = 1'b0;
    larga_d     = 1'b0;
    doble_d     = 1'b0;
    hueco_clr   = pulso_ideal;
    tiempo_clr  = 1'b0;
    ventana_clr = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (pulso_ideal) begin
          estado_d    = PRESIONADO;
          segunda_d   = 1'b0;
          hueco_clr   = 1'b1;
          tiempo_clr  = 1'b1;
          ventana_clr = 1'b1;
        end
      end
      PRESIONADO: begin
        // Long press wins over a release detected in the same cycle
        if (tiempo_fin) begin
          larga_d  = 1'b1;
          estado_d = LARGO;
        end else if (hueco_fin) begin
          if (segunda_q) begin
            doble_d  = 1'b1;
            estado_d = REPOSO;
          end else begin
            estado_d    = ESPERA_DOBLE;
            ventana_clr = 1'b1;
          end
        end
      end
      ESPERA_DOBLE: begin
        // A new press beats window expiry in the same cycle
        if (pulso_ideal) begin
          estado_d   = PRESIONADO;
          segunda_d  = 1'b1;
          tiempo_clr = 1'b1;
          hueco_clr  = 1'b1;
        end else if (ventana_fin) begin
          corta_d  = 1'b1;
          estado_d = REPOSO;
        end
      end
      LARGO: begin
        if (hueco_fin) begin
          estado_d = REPOSO;
        end
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

endmodule

// File: tb/tb_clasificador_pulsacion.sv
// tb/tb_clasificador_pulsacion.sv - scoreboard bench for the press classifier
module tb_clasificador_pulsacion;

  localparam logic [2:0] EV_CORTA = 3'b001;
  localparam logic [2:0] EV_DOBLE = 3'b010;
  localparam logic [2:0] EV_LARGA = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pulso_ideal = 1'b0;
  logic corta, larga, doble, presionado;

  int unsigned cyc = 0;
  int unsigned ult_alto = 0;
  int unsigned t0 = 0;
  int total = 0;
  int bad = 0;
  bit vigilar = 1'b0;
  int caidas = 0;

  typedef struct {
    logic [2:0]  tipo;
    int unsigned ciclo;
  } evento_t;

  evento_t esperados[$];

  clasificador_pulsacion #(
    .CICLOS_MS (10),
    .HUECO_MS  (4),
    .LARGO_MS  (50),
    .DOBLE_MS  (25)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pulso_ideal (pulso_ideal),
    .corta       (corta),
    .larga       (larga),
    .doble       (doble),
    .presionado  (presionado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every event seen must match the head of the expected queue
  always @(negedge clk) begin
    logic [2:0] vis;
    evento_t e;
    vis = {larga, doble, corta};
    if (vis != 3'b000) begin
      total++;
      if (esperados.size() == 0) begin
        bad++;
        $display("FAIL evento_inesperado: got=%b at cycle %0d, expected no event", vis, cyc);
      end else begin
        e = esperados.pop_front();
        if (vis !== e.tipo || cyc !== e.ciclo) begin
          bad++;
          $display("FAIL evento: got=%b at cycle %0d, expected=%b at cycle %0d", vis, cyc, e.tipo, e.ciclo);
        end
      end
    end
  end

  task automatic paso(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      pulso_ideal = v;
      @(negedge clk);
      if (v) ult_alto = cyc;
      if (vigilar && !presionado) caidas++;
    end
  endtask

  task automatic chequear(input string nombre, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", nombre, got, exp);
    end
  endtask

  task automatic esperar(input logic [2:0] tipo, input int unsigned ciclo);
    evento_t e;
    e.tipo  = tipo;
    e.ciclo = ciclo;
    esperados.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    pulso_ideal = 1'b0;
    repeat (3) @(negedge clk);
    chequear("reset_salidas", {28'd0, corta, larga, doble, presionado}, 32'd0);
    rst_n = 1'b1;
    paso(1'b0, 5);

    // single short press
    chequear("presionado_reposo", {31'd0, presionado}, 32'd0);
    paso(1'b1, 1);
    chequear("presionado_sube", {31'd0, presionado}, 32'd1);
    paso(1'b1, 19);
    esperar(EV_CORTA, ult_alto + 290);
    paso(1'b0, 40);
    chequear("presionado_hueco_g", {31'd0, presionado}, 32'd1);
    paso(1'b0, 1);
    chequear("presionado_cae", {31'd0, presionado}, 32'd0);
    paso(1'b0, 300);

    // long hold with one-cycle re-trigger gaps, 700 cycles
    paso(1'b1, 1);
    t0 = cyc;
    esperar(EV_LARGA, t0 + 501);
    vigilar = 1'b1;
    caidas = 0;
    paso(1'b1, 19);
    paso(1'b0, 1);
    for (int k = 0; k < 32; k++) begin
      paso(1'b1, 20);
      paso(1'b0, 1);
    end
    paso(1'b1, 7);
    vigilar = 1'b0;
    chequear("largo_sin_caida", caidas, 32'd0);
    paso(1'b0, 40);
    chequear("largo_presionado_g", {31'd0, presionado}, 32'd1);
    paso(1'b0, 1);
    chequear("largo_presionado_cae", {31'd0, presionado}, 32'd0);
    paso(1'b0, 350);

    // double press: gap of 100 low
    paso(1'b1, 20);
    paso(1'b0, 100);
    paso(1'b1, 20);
    esperar(EV_DOBLE, ult_alto + 41);
    paso(1'b0, 350);

    // two separate short presses: gap of 300 low
    paso(1'b1, 20);
    esperar(EV_CORTA, ult_alto + 290);
    paso(1'b0, 300);
    paso(1'b1, 20);
    esperar(EV_CORTA, ult_alto + 290);
    paso(1'b0, 350);

    // internal 39-cycle gap keeps a single press alive
    paso(1'b1, 1);
    vigilar = 1'b1;
    caidas = 0;
    paso(1'b1, 9);
    paso(1'b0, 39);
    paso(1'b1, 200);
    vigilar = 1'b0;
    chequear("hueco39_sin_caida", caidas, 32'd0);
    esperar(EV_CORTA, ult_alto + 290);
    paso(1'b0, 350);

    // asynchronous reset in the middle of a press
    paso(1'b1, 100);
    chequear("presionado_antes_reset", {31'd0, presionado}, 32'd1);
    rst_n = 1'b0;
    pulso_ideal = 1'b0;
    #1;
    chequear("reset_asincrono", {28'd0, corta, larga, doble, presionado}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    paso(1'b0, 400);
    paso(1'b1, 20);
    esperar(EV_CORTA, ult_alto + 290);
    paso(1'b0, 350);

    chequear("eventos_pendientes", esperados.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
